// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
//   Shared definitions for the CPU-to-external-memory controller:
//     - cpu_mem_state_e : controller state encoding (also driven on the
//                         controller's state_dbg output)
//     - address-map constants (instruction base, data page)
//     - default wait limit for memory handshakes
//     - address-map helper functions used by the controller
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WR_CMD     = 4'd1,
    ST_RD_CMD     = 4'd2,
    ST_RD_WAIT    = 4'd3,
    ST_IF_LO_CMD  = 4'd4,
    ST_IF_LO_WAIT = 4'd5,
    ST_IF_HI_CMD  = 4'd6,
    ST_IF_HI_WAIT = 4'd7,
    ST_HOLD       = 4'd8,
    ST_RELEASE    = 4'd9
  } cpu_mem_state_e;

  // Word base of instruction space in external memory.
  localparam logic [23:0] INSTR_BASE_DEFAULT = 24'h010000;

  // Data accesses live in the lowest 64K-word page.
  localparam logic [7:0]  DATA_PAGE = 8'h00;

  // Cycles a *_CMD / *_WAIT state may wait for the memory before giving up.
  localparam logic [7:0]  TIMEOUT_DEFAULT = 8'd255;

  // Data word address: CPU word address placed in the data page.
  function automatic logic [23:0] data_addr(input logic [15:0] addr);
    return {DATA_PAGE, addr};
  endfunction

  // Instructions are 32 bits wide, stored as two consecutive 16-bit words,
  // so a program address maps to base + 2*addr (low half) and +1 (high half).
  function automatic logic [23:0] instr_lo_addr(input logic [23:0] base,
                                                input logic [15:0] addr);
    return base + {7'b0, addr, 1'b0};
  endfunction

  // States in which the controller waits on the memory (wait counter runs).
  function automatic logic is_mem_state(input cpu_mem_state_e st);
    logic r;
    case (st)
      ST_WR_CMD, ST_RD_CMD, ST_RD_WAIT,
      ST_IF_LO_CMD, ST_IF_LO_WAIT,
      ST_IF_HI_CMD, ST_IF_HI_WAIT: r = 1'b1;
      default:                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage : cpu_mem_pkg

// File: rtl/timeout_ctr.sv
// -----------------------------------------------------------------------------
// timeout_ctr
//   8-bit wait counter with synchronous clear and count enable.
//   terminal is asserted during the LIMIT-th consecutive enabled cycle since
//   the last clear, i.e. the cycle in which the waiting state must give up.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (count -> 0)
//   clear    : synchronous clear, has priority over enable
//   enable   : count this cycle
//   terminal : wait limit reached in this cycle (combinational)
// -----------------------------------------------------------------------------
module timeout_ctr #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && (count != 8'hFF)) begin
      // Saturate rather than wrap so a stuck enable can never re-arm.
      count <= count + 8'd1;
    end
  end

  // count holds the number of completed waiting cycles; the current cycle is
  // number count+1, so the limit is hit when count == LIMIT-1.
  assign terminal = enable && (count == (LIMIT - 8'd1));

endmodule : timeout_ctr

// File: rtl/cpu_mem_ctl.sv
// -----------------------------------------------------------------------------
// cpu_mem_ctl
//   Bridges a simple strobe-based CPU port to a 24-bit word-addressed external
//   memory with a command/ack phase and a separate read-data phase.
//   Data accesses are single 16-bit words; instruction fetches are two 16-bit
//   reads assembled into one 32-bit instruction.
//
// Handshakes
//   CPU side : cpu_read / cpu_write are level strobes held by the CPU. A
//              request is taken in IDLE (write wins over read). cpu_cack
//              pulses for one cycle when the memory accepts the (first)
//              command. Read results are valid while cpu_ready=1; the CPU
//              releases them with cpu_read_done or by dropping cpu_read.
//              After a write or a timeout the controller waits for both
//              strobes to drop so a held strobe cannot start a second access.
//   Mem side : mem_req is held with a stable mem_addr/mem_we/mem_wdata until
//              mem_ack is seen on a rising edge (ack consumes the command).
//              mem_rvalid is honoured only while waiting for read data; stray
//              mem_ack / mem_rvalid in any other state are ignored.
//   Any wait longer than TIMEOUT cycles sets the sticky cpu_err and abandons
//   the access; cpu_err clears when the next request is taken.
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   cpu_addr, cpu_wdata         : CPU word/program address, write data
//   cpu_read, cpu_write         : CPU strobes
//   cpu_instr                   : qualifies cpu_read as an instruction fetch
//   cpu_read_done               : CPU has consumed the read result
//   cpu_rdata, cpu_instr_data   : data / instruction results
//   cpu_busy                    : access in progress (not IDLE, not HOLD)
//   cpu_cack                    : one-cycle command-accepted pulse
//   cpu_ready                   : read result valid (HOLD)
//   cpu_err                     : sticky timeout flag
//   mem_addr, mem_wdata         : memory command address / write data
//   mem_req, mem_we             : memory command strobe / write qualifier
//   mem_ack                     : memory accepted the command
//   mem_rdata, mem_rvalid       : memory read data / valid
//   state_dbg                   : current controller state
// -----------------------------------------------------------------------------
module cpu_mem_ctl
  import cpu_mem_pkg::*;
#(
  parameter logic [23:0] INSTR_BASE = INSTR_BASE_DEFAULT,
  parameter logic [7:0]  TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  // CPU side
  input  logic [15:0]    cpu_addr,
  input  logic [15:0]    cpu_wdata,
  input  logic           cpu_read,
  input  logic           cpu_write,
  input  logic           cpu_instr,
  input  logic           cpu_read_done,
  output logic [15:0]    cpu_rdata,
  output logic [31:0]    cpu_instr_data,
  output logic           cpu_busy,
  output logic           cpu_cack,
  output logic           cpu_ready,
  output logic           cpu_err,
  // Memory side
  output logic [23:0]    mem_addr,
  output logic [15:0]    mem_wdata,
  output logic           mem_req,
  output logic           mem_we,
  input  logic           mem_ack,
  input  logic [15:0]    mem_rdata,
  input  logic           mem_rvalid,
  // Debug
  output cpu_mem_state_e state_dbg
);

  cpu_mem_state_e state;

  logic advance;       // the event the current state is waiting for occurred
  logic ctr_clear;
  logic ctr_enable;
  logic ctr_terminal;

  assign state_dbg = state;

  // Only the handshake the current state expects counts as progress; this is
  // also what makes stray mem_ack / mem_rvalid harmless elsewhere.
  always_comb begin
    advance = 1'b0;
    case (state)
      ST_WR_CMD, ST_RD_CMD,
      ST_IF_LO_CMD, ST_IF_HI_CMD:      advance = mem_ack;
      ST_RD_WAIT, ST_IF_LO_WAIT,
      ST_IF_HI_WAIT:                   advance = mem_rvalid;
      default:                         advance = 1'b0;
    endcase
  end

  // Every entry into a waiting state comes either from a non-waiting state
  // (counter held clear) or from a waiting state that just advanced, so
  // clearing on those two conditions restarts the count on each state entry.
  assign ctr_enable = is_mem_state(state);
  assign ctr_clear  = advance || !ctr_enable;

  timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .clear    (ctr_clear),
    .enable   (ctr_enable),
    .terminal (ctr_terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cpu_rdata      <= 16'h0000;
      cpu_instr_data <= 32'h0000_0000;
      cpu_busy       <= 1'b0;
      cpu_cack       <= 1'b0;
      cpu_ready      <= 1'b0;
      cpu_err        <= 1'b0;
      mem_addr       <= 24'h000000;
      mem_wdata      <= 16'h0000;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
    end else begin
      cpu_cack <= 1'b0;

      if (ctr_terminal && !advance) begin
        // Memory never answered: abandon the access and wait for the CPU
        // to drop its strobes.
        state   <= ST_RELEASE;
        cpu_err <= 1'b1;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cpu_write) begin
              state     <= ST_WR_CMD;
              mem_addr  <= data_addr(cpu_addr);
              mem_wdata <= cpu_wdata;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              cpu_busy  <= 1'b1;
              cpu_err   <= 1'b0;
            end else if (cpu_read && cpu_instr) begin
              state    <= ST_IF_LO_CMD;
              mem_addr <= instr_lo_addr(INSTR_BASE, cpu_addr);
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              cpu_busy <= 1'b1;
              cpu_err  <= 1'b0;
            end else if (cpu_read) begin
              state    <= ST_RD_CMD;
              mem_addr <= data_addr(cpu_addr);
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              cpu_busy <= 1'b1;
              cpu_err  <= 1'b0;
            end
          end

          ST_WR_CMD: begin
            if (mem_ack) begin
              state    <= ST_RELEASE;
              cpu_cack <= 1'b1;
              mem_req  <= 1'b0;
              mem_we   <= 1'b0;
            end
          end

          ST_RD_CMD: begin
            if (mem_ack) begin
              state    <= ST_RD_WAIT;
              cpu_cack <= 1'b1;
              mem_req  <= 1'b0;
            end
          end

          ST_RD_WAIT: begin
            if (mem_rvalid) begin
              state     <= ST_HOLD;
              cpu_rdata <= mem_rdata;
              cpu_busy  <= 1'b0;
              cpu_ready <= 1'b1;
            end
          end

          ST_IF_LO_CMD: begin
            if (mem_ack) begin
              state    <= ST_IF_LO_WAIT;
              cpu_cack <= 1'b1;
              mem_req  <= 1'b0;
            end
          end

          ST_IF_LO_WAIT: begin
            if (mem_rvalid) begin
              // Low half in; issue the high-half fetch at the next word.
              state                <= ST_IF_HI_CMD;
              cpu_instr_data[15:0] <= mem_rdata;
              mem_addr             <= mem_addr + 24'd1;
              mem_req              <= 1'b1;
            end
          end

          ST_IF_HI_CMD: begin
            // The CPU already saw its cack on the first beat.
            if (mem_ack) begin
              state   <= ST_IF_HI_WAIT;
              mem_req <= 1'b0;
            end
          end

          ST_IF_HI_WAIT: begin
            if (mem_rvalid) begin
              state                 <= ST_HOLD;
              cpu_instr_data[31:16] <= mem_rdata;
              cpu_busy              <= 1'b0;
              cpu_ready             <= 1'b1;
            end
          end

          ST_HOLD: begin
            // A CPU that dropped its strobe mid-access still gets the result
            // loaded, but only for this one cycle.
            if (cpu_read_done || !cpu_read) begin
              state     <= ST_IDLE;
              cpu_ready <= 1'b0;
            end
          end

          ST_RELEASE: begin
            if (!cpu_read && !cpu_write) begin
              state    <= ST_IDLE;
              cpu_busy <= 1'b0;
            end
          end

          default: begin
            state     <= ST_IDLE;
            cpu_busy  <= 1'b0;
            cpu_ready <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : cpu_mem_ctl

// File: tb/tb_cpu_mem_ctl.sv
// -----------------------------------------------------------------------------
// tb_cpu_mem_ctl
//   Directed and randomized checks of cpu_mem_ctl against a memory responder
//   and a reference model of the address map, command stream and results.
// -----------------------------------------------------------------------------
module tb_cpu_mem_ctl;
  import cpu_mem_pkg::*;

  localparam logic [23:0] TB_INSTR_BASE = 24'h010000;
  localparam int          TB_TIMEOUT    = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [15:0]    cpu_addr = 16'h0;
  logic [15:0]    cpu_wdata = 16'h0;
  logic           cpu_read = 1'b0;
  logic           cpu_write = 1'b0;
  logic           cpu_instr = 1'b0;
  logic           cpu_read_done = 1'b0;
  logic [15:0]    cpu_rdata;
  logic [31:0]    cpu_instr_data;
  logic           cpu_busy;
  logic           cpu_cack;
  logic           cpu_ready;
  logic           cpu_err;
  logic [23:0]    mem_addr;
  logic [15:0]    mem_wdata;
  logic           mem_req;
  logic           mem_we;
  logic           mem_ack;
  logic [15:0]    mem_rdata;
  logic           mem_rvalid;
  cpu_mem_state_e state_dbg;

  logic resp_ack, resp_rvalid;
  logic force_ack = 1'b0;
  logic force_rvalid = 1'b0;
  assign mem_ack    = resp_ack | force_ack;
  assign mem_rvalid = resp_rvalid | force_rvalid;

  cpu_mem_ctl dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_instr      (cpu_instr),
    .cpu_read_done  (cpu_read_done),
    .cpu_rdata      (cpu_rdata),
    .cpu_instr_data (cpu_instr_data),
    .cpu_busy       (cpu_busy),
    .cpu_cack       (cpu_cack),
    .cpu_ready      (cpu_ready),
    .cpu_err        (cpu_err),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .state_dbg      (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  // Command record: {we, addr[23:0], wdata[15:0]} (wdata zero for reads).
  logic [40:0] exp_q[$];
  logic [40:0] obs_q[$];
  logic [15:0] mem_array [logic [23:0]];
  int n_cmp = 0;
  int n_fail = 0;
  int cack_cnt = 0;

  // Memory responder knobs.
  bit resp_on = 1'b1;
  int ack_dly = 0;
  int rv_dly  = 0;
  logic        lat_we;
  logic [23:0] lat_addr;

  // ---------------- memory responder ----------------
  initial begin
    resp_ack = 1'b0;
    resp_rvalid = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      resp_rvalid = 1'b0;
      if (resp_on && mem_req) begin
        repeat (ack_dly) @(negedge clk);
        if (mem_req) begin
          lat_we = mem_we;
          lat_addr = mem_addr;
          obs_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 16'h0});
          resp_ack = 1'b1;
          @(negedge clk);
          resp_ack = 1'b0;
          if (!lat_we) begin
            repeat (rv_dly) @(negedge clk);
            mem_rdata = mem_array.exists(lat_addr) ? mem_array[lat_addr] : 16'h0;
            resp_rvalid = 1'b1;
          end
        end
      end
    end
  end

  // cack pulse monitor.
  always @(posedge clk) begin
    #1;
    if (cpu_cack === 1'b1) cack_cnt++;
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking / driver tasks ----------------
  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_ncmd"}, 48'(obs_q.size()), 48'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_cmd"}, 48'(obs_q.pop_front()), 48'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] d,
                          input bit with_read);
    int c0;
    bit got;
    c0 = cack_cnt;
    exp_q.push_back({1'b1, 8'h00, a, d});
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_write = 1'b1; cpu_read = with_read; cpu_instr = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (cack_cnt != c0) begin got = 1'b1; break; end
    end
    chk({tag, "_cack_seen"}, 48'(got), 48'd1);
    cpu_write = 1'b0; cpu_read = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!cpu_busy) begin got = 1'b1; break; end
    end
    chk({tag, "_busy_released"}, 48'(got), 48'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_cack_count"}, 48'(cack_cnt - c0), 48'd1);
    chk({tag, "_err"}, 48'(cpu_err), 48'd0);
    sb_check(tag);
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input bit instr,
                         input logic [15:0] d_lo, input logic [15:0] d_hi, input int exp_lat);
    logic [23:0] lo_addr;
    logic [31:0] exp_data;
    int c0;
    int k;
    bit got;
    c0 = cack_cnt;
    if (instr) begin
      lo_addr = TB_INSTR_BASE + 24'(a) * 24'd2;
      mem_array[lo_addr] = d_lo;
      mem_array[lo_addr + 24'd1] = d_hi;
      exp_q.push_back({1'b0, lo_addr, 16'h0});
      exp_q.push_back({1'b0, lo_addr + 24'd1, 16'h0});
      exp_data = {d_hi, d_lo};
    end else begin
      lo_addr = {8'h00, a};
      mem_array[lo_addr] = d_lo;
      exp_q.push_back({1'b0, lo_addr, 16'h0});
      exp_data = {16'h0, d_lo};
    end
    @(negedge clk);
    cpu_addr = a; cpu_instr = instr; cpu_read = 1'b1; cpu_write = 1'b0;
    got = 1'b0;
    for (k = 1; k <= 600; k++) begin
      @(posedge clk);
      #1;
      if (cpu_ready) begin got = 1'b1; break; end
    end
    chk({tag, "_ready_seen"}, 48'(got), 48'd1);
    if (exp_lat > 0) chk({tag, "_latency"}, 48'(k), 48'(exp_lat));
    if (instr) chk({tag, "_instr_data"}, 48'(cpu_instr_data), 48'(exp_data));
    else       chk({tag, "_rdata"}, 48'(cpu_rdata), 48'(exp_data));
    repeat (2) @(negedge clk);
    chk({tag, "_ready_hold"}, 48'(cpu_ready), 48'd1);
    chk({tag, "_busy_in_hold"}, 48'(cpu_busy), 48'd0);
    cpu_read_done = 1'b1;
    @(negedge clk);
    cpu_read_done = 1'b0; cpu_read = 1'b0; cpu_instr = 1'b0;
    chk({tag, "_ready_drop"}, 48'(cpu_ready), 48'd0);
    chk({tag, "_busy_after"}, 48'(cpu_busy), 48'd0);
    chk({tag, "_err"}, 48'(cpu_err), 48'd0);
    chk({tag, "_cack_count"}, 48'(cack_cnt - c0), 48'd1);
    sb_check(tag);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    bit got;
    int op;
    logic [15:0] ra, rd, rd2;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_flags", 48'({cpu_busy, cpu_cack, cpu_ready, cpu_err, mem_req, mem_we}), 48'd0);
    chk("rst_mem_addr", 48'(mem_addr), 48'd0);
    chk("rst_rdata", 48'({cpu_rdata, cpu_instr_data}), 48'd0);
    chk("rst_state", 48'(state_dbg), 48'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write with a slow ack.
    ack_dly = 2; rv_dly = 0;
    do_write("wr_beef", 16'h0040, 16'hBEEF, 1'b0);

    // Zero-wait data read: 3-cycle latency, ready held until read_done.
    ack_dly = 0; rv_dly = 0;
    do_read("rd_1234", 16'h1234, 1'b0, 16'h5A5A, 16'h0, 3);

    // Zero-wait instruction fetch: 5-cycle latency, two beats, one cack.
    do_read("if_0003", 16'h0003, 1'b1, 16'h1111, 16'h2222, 5);

    // Write wins over a simultaneous read; no read command follows.
    ack_dly = 1;
    do_write("wr_and_rd", 16'h0102, 16'h3C3C, 1'b1);

    // CPU drops its read strobe mid-access: result loaded, ready for one cycle.
    ack_dly = 1; rv_dly = 3;
    c0 = cack_cnt;
    mem_array[24'h000777] = 16'hC0DE;
    exp_q.push_back({1'b0, 24'h000777, 16'h0});
    @(negedge clk);
    cpu_addr = 16'h0777; cpu_read = 1'b1; cpu_instr = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cack_cnt != c0) begin got = 1'b1; break; end
    end
    chk("drop_cack_seen", 48'(got), 48'd1);
    cpu_read = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (cpu_ready) begin got = 1'b1; break; end
    end
    chk("drop_ready_seen", 48'(got), 48'd1);
    chk("drop_rdata", 48'(cpu_rdata), 48'hC0DE);
    @(posedge clk);
    #1;
    chk("drop_ready_one_cycle", 48'(cpu_ready), 48'd0);
    chk("drop_state_idle", 48'(state_dbg), 48'(ST_IDLE));
    sb_check("drop");

    // Stray mem_ack / mem_rvalid in IDLE are ignored.
    c0 = cack_cnt;
    @(negedge clk);
    force_ack = 1'b1; force_rvalid = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0; force_rvalid = 1'b0;
    chk("spur_state", 48'(state_dbg), 48'(ST_IDLE));
    chk("spur_flags", 48'({cpu_busy, cpu_cack, cpu_ready, mem_req}), 48'd0);
    chk("spur_rdata", 48'(cpu_rdata), 48'hC0DE);
    chk("spur_cack", 48'(cack_cnt - c0), 48'd0);

    // Randomized mix of writes, data reads and instruction fetches.
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2);
      ra = 16'($urandom);
      rd = 16'($urandom);
      rd2 = 16'($urandom);
      ack_dly = $urandom_range(0, 3);
      rv_dly = $urandom_range(0, 3);
      case (op)
        0:       do_write("rnd_wr", ra, rd, 1'($urandom_range(0, 1)));
        1:       do_read("rnd_rd", ra, 1'b0, rd, 16'h0, 0);
        default: do_read("rnd_if", ra, 1'b1, rd, rd2, 0);
      endcase
    end

    // Timeout: no ack for TIMEOUT cycles -> sticky error, then cleared.
    resp_on = 1'b0;
    @(negedge clk);
    cpu_addr = 16'h00AA; cpu_wdata = 16'h5555; cpu_write = 1'b1;
    @(posedge clk);
    #1;
    chk("tmo_entered", 48'(state_dbg), 48'(ST_WR_CMD));
    repeat (TB_TIMEOUT - 1) @(posedge clk);
    #1;
    chk("tmo_err_not_yet", 48'(cpu_err), 48'd0);
    @(posedge clk);
    #1;
    chk("tmo_err_set", 48'(cpu_err), 48'd1);
    chk("tmo_req_dropped", 48'(mem_req), 48'd0);
    chk("tmo_busy_release", 48'(cpu_busy), 48'd1);
    @(negedge clk);
    cpu_write = 1'b0;
    repeat (2) @(negedge clk);
    chk("tmo_idle_busy", 48'(cpu_busy), 48'd0);
    chk("tmo_err_sticky", 48'(cpu_err), 48'd1);
    resp_on = 1'b1; ack_dly = 0; rv_dly = 0;
    do_read("tmo_next_rd", 16'h0BAD, 1'b0, 16'h7E57, 16'h0, 3);

    // Reset during IF_HI_WAIT; the late read beat must be ignored.
    ack_dly = 0; rv_dly = 6;
    mem_array[TB_INSTR_BASE + 24'h000020] = 16'hAAAA;
    mem_array[TB_INSTR_BASE + 24'h000021] = 16'hBBBB;
    exp_q.push_back({1'b0, TB_INSTR_BASE + 24'h000020, 16'h0});
    exp_q.push_back({1'b0, TB_INSTR_BASE + 24'h000021, 16'h0});
    @(negedge clk);
    cpu_addr = 16'h0010; cpu_instr = 1'b1; cpu_read = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (state_dbg == ST_IF_HI_WAIT) begin got = 1'b1; break; end
    end
    chk("rstmid_reached", 48'(got), 48'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_flags", 48'({cpu_busy, cpu_cack, cpu_ready, cpu_err, mem_req, mem_we}), 48'd0);
    chk("rstmid_mem", 48'({mem_addr, mem_wdata}), 48'd0);
    chk("rstmid_data", 48'({cpu_rdata, cpu_instr_data}), 48'd0);
    chk("rstmid_state", 48'(state_dbg), 48'(ST_IDLE));
    cpu_read = 1'b0; cpu_instr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstmid_late_state", 48'(state_dbg), 48'(ST_IDLE));
    chk("rstmid_late_instr", 48'(cpu_instr_data), 48'd0);
    chk("rstmid_late_ready", 48'({cpu_ready, cpu_busy}), 48'd0);
    sb_check("rstmid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_cpu_mem_ctl

// File: doc/cpu_mem_ctl.md
CPU_MEM_CTL -- requirements
Module: cpu_mem_ctl

Interface
REQ-001 Parameter: INSTR_BASE, 24'h010000, word base address of instruction space in external memory.
REQ-002 Parameter: TIMEOUT, 8'd255, maximum cycles to wait for mem_ack or mem_rvalid.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cpu_addr  in  16  CPU word address (data) or program address (instruction).
REQ-006 cpu_wdata  in  16  CPU write data.
REQ-007 cpu_read, cpu_write, cpu_instr  in  1 each  CPU read strobe, write strobe, instruction-access qualifier.
REQ-008 cpu_read_done  in  1  CPU has consumed read data.
REQ-009 cpu_rdata  out  16  data read result; cpu_instr_data  out  32  assembled instruction.
REQ-010 cpu_busy, cpu_cack, cpu_ready, cpu_err  out  1 each  busy, command-accepted pulse, data-valid, timeout flag.
REQ-011 mem_addr  out  24; mem_wdata  out  16; mem_req, mem_we  out  1 each  memory command.
REQ-012 mem_ack  in  1  command accepted; mem_rdata  in  16; mem_rvalid  in  1  read data valid.

Function
REQ-013 States: IDLE, WR_CMD, RD_CMD, RD_WAIT, IF_LO_CMD, IF_LO_WAIT, IF_HI_CMD, IF_HI_WAIT, HOLD, RELEASE.
REQ-014 IDLE: cpu_write -> latch addr/wdata, WR_CMD; else cpu_read & cpu_instr -> IF_LO_CMD; else cpu_read -> RD_CMD; write wins over simultaneous read.
REQ-015 Address map: data = {8'h00, addr}; instruction low = INSTR_BASE + {7'b0, addr, 1'b0}; high = low + 1.
REQ-016 *_CMD states drive mem_req=1 with latched address; mem_we=1 only in WR_CMD; mem_req=0 elsewhere.
REQ-017 WR_CMD on mem_ack -> cpu_cack pulse one cycle, RELEASE.
REQ-018 RD_CMD on mem_ack -> cpu_cack pulse, RD_WAIT; RD_WAIT on mem_rvalid -> cpu_rdata<=mem_rdata, HOLD.
REQ-019 IF_LO_CMD on mem_ack -> cpu_cack pulse, IF_LO_WAIT; on mem_rvalid -> cpu_instr_data[15:0]<=mem_rdata, IF_HI_CMD.
REQ-020 IF_HI_CMD on mem_ack -> IF_HI_WAIT (no cack); on mem_rvalid -> cpu_instr_data[31:16]<=mem_rdata, HOLD.
REQ-021 HOLD: cpu_ready=1; exit to IDLE when cpu_read_done=1 or cpu_read=0.
REQ-022 RELEASE: wait until cpu_read=0 and cpu_write=0, then IDLE; prevents retriggering on a held strobe.
REQ-023 cpu_busy=1 in every state except IDLE and HOLD.
REQ-024 CPU strobe drop mid-transaction: memory sequence completes; result loaded but HOLD exits next cycle.
REQ-025 mem_rvalid or mem_ack outside a state expecting it: ignored, no state change.
REQ-026 8-bit wait counter clears on each state entry, increments in *_CMD/*_WAIT; reaching TIMEOUT -> cpu_err=1, RELEASE.
REQ-027 cpu_err sticky; cleared when next request is accepted in IDLE.
REQ-028 Latency minimum: data read 3 cycles request-to-ready with zero-wait memory; instruction 5 cycles.

Reset
REQ-029 rst -> state IDLE, counter 0, cpu_rdata 0, cpu_instr_data 0, all strobe/flag outputs 0, mem_addr 0, mem_wdata 0.
REQ-030 rst mid-transaction aborts immediately; memory side must tolerate mem_req dropping.

Structure
REQ-031 State encoding and address-map constants (INSTR_BASE default, data page 8'h00) in shared package cpu_mem_pkg.
REQ-032 Single module; wait counter may be sub-module timeout_ctr (clear, enable, terminal-count output).

Verification
REQ-033 Write addr 16'h0040 data 16'hBEEF, mem_ack after 2 cycles -> mem_addr 24'h000040, mem_we=1, one cack pulse, busy low after strobe drops.
REQ-034 Data read addr 16'h1234, rvalid data 16'h5A5A -> cpu_rdata 16'h5A5A, ready held until read_done.
REQ-035 Instruction read addr 16'h0003, beats 16'h1111 then 16'h2222 -> addresses 24'h010006, 24'h010007, cpu_instr_data 32'h22221111, single cack.
REQ-036 Simultaneous cpu_read and cpu_write in IDLE -> write performed, no read command issued.
REQ-037 No mem_ack for 255 cycles -> cpu_err=1, RELEASE; next request clears cpu_err.
REQ-038 rst asserted in IF_HI_WAIT -> all outputs zero same cycle; late mem_rvalid ignored.
